// File: rtl/cmac_tx_gate.sv
`default_nettype none
// ============================================================================
// Module   : cmac_tx_gate
// Brief    : Gates the application AXI-Stream toward the CMAC TX path on RX
//            alignment. Transmission opens only after alignment has been
//            stable for SETTLE_CYCLES and only on a packet boundary; a packet
//            cut by loss of alignment is closed with a single error beat.
// Revision : 1.0 - initial release
// ============================================================================
module cmac_tx_gate #(
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic         tx_clk,
  input  logic         sys_reset_in,
  input  logic         stat_rx_aligned,
  input  logic [511:0] tx_in_tdata,
  input  logic [63:0]  tx_in_tkeep,
  input  logic         tx_in_tlast,
  input  logic         tx_in_tuser,
  input  logic         tx_in_tvalid,
  output logic         tx_in_tready,
  output logic [511:0] tx_out_tdata,
  output logic [63:0]  tx_out_tkeep,
  output logic         tx_out_tlast,
  output logic         tx_out_tuser,
  output logic         tx_out_tvalid,
  input  logic         tx_out_tready,
  output logic         tx_active,
  output logic [31:0]  dropped_packets,
  output logic [31:0]  aborted_packets
);

  typedef enum logic [1:0] {
    ST_DOWN  = 2'd0,
    ST_UP    = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  localparam logic [15:0] c_settle_max = 16'(SETTLE_CYCLES);
  localparam logic [31:0] c_cnt_max    = 32'hFFFF_FFFF;

  logic [3:0]  r_sync;
  logic        w_sync_aligned;
  state_t      r_state;
  state_t      w_state_next;
  logic        r_in_mid;
  logic        w_in_mid_next;
  logic        w_in_ready;
  logic        w_in_acc;
  logic [15:0] r_settle_cnt;
  logic [31:0] r_dropped;
  logic [31:0] r_aborted;
  logic        w_drop_evt;
  logic        w_abort_evt;

  assign w_sync_aligned  = r_sync[3];
  assign w_in_acc        = tx_in_tvalid & w_in_ready;
  assign w_in_mid_next   = w_in_acc ? ~tx_in_tlast : r_in_mid;
  assign tx_in_tready    = w_in_ready;
  assign tx_active       = (r_state == ST_UP);
  assign dropped_packets = r_dropped;
  assign aborted_packets = r_aborted;

  // Four-stage synchronizer bringing the PCS alignment into the TX domain.
  always_ff @(posedge tx_clk or posedge sys_reset_in) begin
    if (sys_reset_in) r_sync <= '0;
    else              r_sync <= {r_sync[2:0], stat_rx_aligned};
  end

  // Input ready: sink everything while down, follow the MAC while up, stall in abort.
  always_comb begin
    w_in_ready = 1'b1;
    if (r_state == ST_UP)         w_in_ready = tx_out_tready;
    else if (r_state == ST_ABORT) w_in_ready = 1'b0;
  end

  // Next state, output mux and counter events.
  always_comb begin
    w_state_next  = r_state;
    tx_out_tdata  = '0;
    tx_out_tkeep  = '0;
    tx_out_tlast  = 1'b0;
    tx_out_tuser  = 1'b0;
    tx_out_tvalid = 1'b0;
    w_drop_evt    = 1'b0;
    w_abort_evt   = 1'b0;
    case (r_state)
      ST_DOWN: begin
        w_drop_evt = w_in_acc & tx_in_tlast;
        // Open only on a packet boundary: idle between packets, or on the
        // tail beat of a packet that is itself being discarded.
        if ((r_settle_cnt == c_settle_max) && w_sync_aligned &&
            ((!r_in_mid && !w_in_acc) || (w_in_acc && tx_in_tlast)))
          w_state_next = ST_UP;
      end
      ST_UP: begin
        tx_out_tdata  = tx_in_tdata;
        tx_out_tkeep  = tx_in_tkeep;
        tx_out_tlast  = tx_in_tlast;
        tx_out_tuser  = tx_in_tuser;
        tx_out_tvalid = tx_in_tvalid;
        if (!w_sync_aligned)
          w_state_next = w_in_mid_next ? ST_ABORT : ST_DOWN;
      end
      ST_ABORT: begin
        // Error-terminated closing beat for the packet cut short at the MAC.
        tx_out_tkeep  = '1;
        tx_out_tlast  = 1'b1;
        tx_out_tuser  = 1'b1;
        tx_out_tvalid = 1'b1;
        if (tx_out_tready) begin
          w_state_next = ST_DOWN;
          w_abort_evt  = 1'b1;
        end
      end
      default: w_state_next = ST_DOWN;
    endcase
  end

  // State register.
  always_ff @(posedge tx_clk or posedge sys_reset_in) begin
    if (sys_reset_in) r_state <= ST_DOWN;
    else              r_state <= w_state_next;
  end

  // Input packet-boundary tracker, independent of gate state.
  always_ff @(posedge tx_clk or posedge sys_reset_in) begin
    if (sys_reset_in) r_in_mid <= 1'b0;
    else              r_in_mid <= w_in_mid_next;
  end

  // Settle counter; held at zero outside DOWN so every DOWN entry starts fresh.
  always_ff @(posedge tx_clk or posedge sys_reset_in) begin
    if (sys_reset_in)                                  r_settle_cnt <= '0;
    else if (r_state != ST_DOWN || !w_sync_aligned)    r_settle_cnt <= '0;
    else if (r_settle_cnt != c_settle_max)             r_settle_cnt <= r_settle_cnt + 16'd1;
  end

  // Saturating dropped/aborted packet counters.
  always_ff @(posedge tx_clk or posedge sys_reset_in) begin
    if (sys_reset_in) begin
      r_dropped <= '0;
      r_aborted <= '0;
    end else begin
      if (w_drop_evt && r_dropped != c_cnt_max)  r_dropped <= r_dropped + 32'd1;
      if (w_abort_evt && r_aborted != c_cnt_max) r_aborted <= r_aborted + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmac_tx_gate.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmac_tx_gate
// Brief    : Self-checking bench for cmac_tx_gate: directed scenarios with
//            literal expectations plus randomized traffic against a
//            behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmac_tx_gate;

  localparam int S     = 16;
  localparam int M_OFF = 0;
  localparam int M_ON  = 1;
  localparam int M_ABT = 2;

  logic         tx_clk = 1'b0;
  logic         sys_reset_in;
  logic         stat_rx_aligned;
  logic [511:0] tx_in_tdata;
  logic [63:0]  tx_in_tkeep;
  logic         tx_in_tlast, tx_in_tuser, tx_in_tvalid, tx_in_tready;
  logic [511:0] tx_out_tdata;
  logic [63:0]  tx_out_tkeep;
  logic         tx_out_tlast, tx_out_tuser, tx_out_tvalid, tx_out_tready;
  logic         tx_active;
  logic [31:0]  dropped_packets, aborted_packets;

  int n_vec = 0;
  int n_mis = 0;
  int n_xfer = 0;

  // Reference model state: gate mode, packet-in-progress flag, length of the
  // current run of aligned cycles (capped), event counts, and a 4-deep delay
  // line standing in for the synchronizer latency.
  int          m_mode;
  bit          m_mid;
  int          m_settle;
  logic [31:0] m_drop, m_abort;
  bit          m_aq[$];

  always #5 tx_clk = ~tx_clk;

  cmac_tx_gate #(.SETTLE_CYCLES(S)) dut (
    .tx_clk(tx_clk), .sys_reset_in(sys_reset_in), .stat_rx_aligned(stat_rx_aligned),
    .tx_in_tdata(tx_in_tdata), .tx_in_tkeep(tx_in_tkeep), .tx_in_tlast(tx_in_tlast),
    .tx_in_tuser(tx_in_tuser), .tx_in_tvalid(tx_in_tvalid), .tx_in_tready(tx_in_tready),
    .tx_out_tdata(tx_out_tdata), .tx_out_tkeep(tx_out_tkeep), .tx_out_tlast(tx_out_tlast),
    .tx_out_tuser(tx_out_tuser), .tx_out_tvalid(tx_out_tvalid), .tx_out_tready(tx_out_tready),
    .tx_active(tx_active), .dropped_packets(dropped_packets), .aborted_packets(aborted_packets)
  );

  function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_mode   = M_OFF;
    m_mid    = 1'b0;
    m_settle = 0;
    m_drop   = '0;
    m_abort  = '0;
    m_aq     = '{1'b0, 1'b0, 1'b0, 1'b0};
  endfunction

  function automatic bit exp_ready();
    if (m_mode == M_OFF) return 1'b1;
    if (m_mode == M_ON)  return tx_out_tready;
    return 1'b0;
  endfunction

  // Per-cycle comparison of every meaningful DUT output against the model.
  task automatic compare();
    bit ev;
    ev = (m_mode == M_ON) ? tx_in_tvalid : (m_mode == M_ABT);
    chk("in_tready", 512'(tx_in_tready), 512'(exp_ready()));
    chk("out_tvalid", 512'(tx_out_tvalid), 512'(ev));
    chk("tx_active", 512'(tx_active), 512'(m_mode == M_ON));
    chk("dropped", 512'(dropped_packets), 512'(m_drop));
    chk("aborted", 512'(aborted_packets), 512'(m_abort));
    if (ev && m_mode == M_ON) begin
      chk("pass_tdata", tx_out_tdata, tx_in_tdata);
      chk("pass_tkeep", 512'(tx_out_tkeep), 512'(tx_in_tkeep));
      chk("pass_tlast", 512'(tx_out_tlast), 512'(tx_in_tlast));
      chk("pass_tuser", 512'(tx_out_tuser), 512'(tx_in_tuser));
    end else if (ev) begin
      chk("abort_tdata", tx_out_tdata, 512'd0);
      chk("abort_tkeep", 512'(tx_out_tkeep), 512'(64'hFFFF_FFFF_FFFF_FFFF));
      chk("abort_tlast", 512'(tx_out_tlast), 512'd1);
      chk("abort_tuser", 512'(tx_out_tuser), 512'd1);
    end
    if (tx_out_tvalid === 1'b1 && tx_out_tready === 1'b1) n_xfer++;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic advance();
    bit sync, acc, mid_after, en;
    if (sys_reset_in) begin
      model_reset();
      return;
    end
    sync      = m_aq[0];
    acc       = tx_in_tvalid && exp_ready();
    mid_after = acc ? !tx_in_tlast : m_mid;
    if (m_mode == M_OFF) begin
      en = (m_settle == S) && sync && ((!m_mid && !acc) || (acc && tx_in_tlast));
      if (acc && tx_in_tlast && m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
      m_settle = sync ? ((m_settle < S) ? m_settle + 1 : S) : 0;
      if (en) begin
        m_mode   = M_ON;
        m_settle = 0;
      end
    end else if (m_mode == M_ON) begin
      if (!sync) m_mode = mid_after ? M_ABT : M_OFF;
    end else begin
      if (tx_out_tready) begin
        m_mode = M_OFF;
        if (m_abort != 32'hFFFF_FFFF) m_abort = m_abort + 1;
      end
    end
    m_mid = mid_after;
    void'(m_aq.pop_front());
    m_aq.push_back(stat_rx_aligned);
  endtask

  // One clock: settle, compare, update model, move to the next negedge.
  task automatic step();
    #1;
    compare();
    advance();
    @(posedge tx_clk);
    @(negedge tx_clk);
  endtask

  task automatic idle();
    tx_in_tvalid = 1'b0;
    tx_in_tlast  = 1'b0;
    tx_in_tuser  = 1'b0;
  endtask

  task automatic beat(input bit last);
    for (int w = 0; w < 16; w++) tx_in_tdata[w*32 +: 32] = $urandom();
    tx_in_tkeep  = {$urandom(), $urandom()};
    tx_in_tuser  = ($urandom_range(7) == 0);
    tx_in_tlast  = last;
    tx_in_tvalid = 1'b1;
  endtask

  task automatic wait_active(input bit want, input int bound, output int cnt);
    cnt = 0;
    while (tx_active !== want && cnt < bound) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    int cnt;
    sys_reset_in    = 1'b1;
    stat_rx_aligned = 1'b0;
    tx_out_tready   = 1'b1;
    tx_in_tdata     = '0;
    tx_in_tkeep     = '0;
    idle();
    model_reset();
    @(negedge tx_clk);
    step();
    step();
    chk("rst_active", 512'(tx_active), 512'd0);
    chk("rst_tready", 512'(tx_in_tready), 512'd1);
    chk("rst_tvalid", 512'(tx_out_tvalid), 512'd0);
    chk("rst_dropped", 512'(dropped_packets), 512'd0);
    sys_reset_in = 1'b0;
    step();
    step();

    // Enable latency with no traffic: 4 sync + 16 settle + 1 state register.
    stat_rx_aligned = 1'b1;
    wait_active(1'b1, 200, cnt);
    chk("settle_latency", 512'(cnt), 512'd21);

    // Partial packet present at settle completion is discarded to its tail.
    stat_rx_aligned = 1'b0;
    wait_active(1'b0, 20, cnt);
    beat(1'b0); step();
    idle();
    stat_rx_aligned = 1'b1;
    for (int i = 0; i < 25; i++) step();
    chk("midpkt_held_down", 512'(tx_active), 512'd0);
    beat(1'b0); step();
    beat(1'b0); step();
    chk("midpkt_still_down", 512'(tx_active), 512'd0);
    beat(1'b1); step();
    idle();
    chk("midpkt_up_on_tail", 512'(tx_active), 512'd1);
    chk("midpkt_dropped", 512'(dropped_packets), 512'd1);
    n_xfer = 0;
    beat(1'b0); step();
    beat(1'b0); step();
    beat(1'b1); step();
    idle(); step();
    chk("next_pkt_fwd_beats", 512'(n_xfer), 512'd3);

    // Alignment lost mid-packet; abort beat held 10 cycles with MAC stalled.
    beat(1'b0); step();
    beat(1'b0); step();
    idle();
    tx_out_tready   = 1'b0;
    stat_rx_aligned = 1'b0;
    n_xfer = 0;
    wait_active(1'b0, 20, cnt);
    for (int i = 0; i < 10; i++) begin
      chk("abort_hold_valid", 512'(tx_out_tvalid), 512'd1);
      chk("abort_hold_keep", 512'(tx_out_tkeep), 512'(64'hFFFF_FFFF_FFFF_FFFF));
      step();
    end
    tx_out_tready = 1'b1;
    step();
    chk("abort_one_xfer", 512'(n_xfer), 512'd1);
    chk("aborted_cnt", 512'(aborted_packets), 512'd1);
    chk("abort_done_valid", 512'(tx_out_tvalid), 512'd0);
    for (int i = 3; i <= 6; i++) begin
      beat(i == 6); step();
    end
    idle(); step();
    chk("abort_tail_dropped", 512'(dropped_packets), 512'd2);
    chk("abort_tail_no_xfer", 512'(n_xfer), 512'd1);

    // Alignment lost between packets: straight to DOWN, no abort beat.
    stat_rx_aligned = 1'b1;
    wait_active(1'b1, 60, cnt);
    beat(1'b0); step();
    beat(1'b1); step();
    idle();
    n_xfer = 0;
    stat_rx_aligned = 1'b0;
    wait_active(1'b0, 20, cnt);
    step(); step();
    chk("gap_drop_no_abort", 512'(n_xfer), 512'd0);
    chk("gap_drop_dropped", 512'(dropped_packets), 512'd2);
    chk("gap_drop_aborted", 512'(aborted_packets), 512'd1);

    // Reset pulsed in UP mid-packet.
    stat_rx_aligned = 1'b1;
    wait_active(1'b1, 60, cnt);
    beat(1'b0); step();
    beat(1'b0);
    #2;
    sys_reset_in = 1'b1;
    model_reset();
    #1;
    chk("rstmid_tvalid", 512'(tx_out_tvalid), 512'd0);
    chk("rstmid_tready", 512'(tx_in_tready), 512'd1);
    chk("rstmid_active", 512'(tx_active), 512'd0);
    chk("rstmid_dropped", 512'(dropped_packets), 512'd0);
    chk("rstmid_aborted", 512'(aborted_packets), 512'd0);
    @(negedge tx_clk);
    step();
    sys_reset_in = 1'b0;
    n_xfer = 0;
    beat(1'b0); step();
    beat(1'b1); step();
    idle(); step();
    chk("rstmid_no_abort", 512'(n_xfer), 512'd0);
    chk("rstmid_tail_dropped", 512'(dropped_packets), 512'd1);

    // Randomized traffic and alignment flaps against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) == 0) stat_rx_aligned = ~stat_rx_aligned;
      if ($urandom_range(99) < 70) beat($urandom_range(3) == 0);
      else                         idle();
      tx_out_tready = ($urandom_range(3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 1000000");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/cmac_tx_gate.md
CMAC_TX_GATE -- requirements
Module: cmac_tx_gate

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1024: consecutive tx_clk cycles that sync_aligned must stay high before transmission is enabled; range 1 to 65535.
REQ-002 SHALL have port tx_clk, input, 1 bit: the only clock; CMAC gt_txusrclk2, 322265625 Hz.
REQ-003 SHALL have port sys_reset_in, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port stat_rx_aligned, input, 1 bit: CMAC PCS alignment, asynchronous to tx_clk.
REQ-005 SHALL have ports tx_in_tdata[511:0], tx_in_tkeep[63:0], tx_in_tlast, tx_in_tuser, tx_in_tvalid (inputs) and tx_in_tready (output): the application AXI-Stream slave.
REQ-006 SHALL have ports tx_out_tdata[511:0], tx_out_tkeep[63:0], tx_out_tlast, tx_out_tuser, tx_out_tvalid (outputs) and tx_out_tready (input): the AXI-Stream master to CMAC axis_tx; tuser drives tx_errin.
REQ-007 SHALL have port tx_active, output, 1 bit: high only in state UP.
REQ-008 SHALL have ports dropped_packets[31:0] and aborted_packets[31:0], outputs: saturating event counters.

Function
REQ-009 SHALL synchronize stat_rx_aligned to tx_clk through a 4-flop synchronizer, each flop initialized to 0, producing sync_aligned.
REQ-010 SHALL keep an input-packet flag, in_mid: set on an accepted beat with tlast=0, cleared on an accepted beat with tlast=1, tracked in every state.
REQ-011 SHALL implement three states: DOWN, UP and ABORT.
REQ-012 In DOWN, SHALL drive tx_in_tready=1 and tx_out_tvalid=0; every input beat is discarded.
REQ-013 In DOWN, SHALL keep settle_cnt: it increments while sync_aligned=1, saturates at SETTLE_CYCLES, and clears to 0 in any cycle sync_aligned=0.
REQ-014 DOWN to UP SHALL occur when settle_cnt==SETTLE_CYCLES and sync_aligned=1 and either:
- in_mid=0 with no accepted beat this cycle, or
- this cycle accepts a beat with tlast=1.
REQ-015 Packets SHALL never start mid-stream: a partial input packet present at enable time is discarded up to and including its tlast.
REQ-016 In UP, SHALL pass through combinationally:
- tx_out_tdata, tkeep, tlast, tuser, tvalid copy the corresponding tx_in_* signals;
- tx_in_tready = tx_out_tready;
- latency is zero cycles.
REQ-017 In UP, when sync_aligned=0:
- next state is ABORT if in_mid=1 after this cycle's handshake, else DOWN;
- the current cycle still passes through.
REQ-018 In ABORT, SHALL drive:
- tx_in_tready=0 and tx_out_tvalid=1;
- tx_out_tdata=0, tx_out_tkeep=all ones, tx_out_tlast=1, tx_out_tuser=1.
REQ-019 ABORT SHALL hold its beat stable until tx_out_tready=1, then go to DOWN and increment aborted_packets.
REQ-020 dropped_packets SHALL increment on each accepted input beat with tlast=1 while in DOWN, including the tail of an aborted packet.
REQ-021 Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-022 settle_cnt SHALL clear to 0 on entry to DOWN.
REQ-023 sync_aligned returning high during ABORT SHALL NOT shorten ABORT.

Reset
REQ-024 While sys_reset_in=1, SHALL asynchronously force:
- state DOWN, tx_active=0;
- in_mid=0, settle_cnt=0, both counters 0;
- synchronizer flops 0.
REQ-025 During reset, SHALL drive tx_out_tvalid=0 and tx_in_tready=1.
REQ-026 Reset asserted mid-packet or in ABORT SHALL produce no abort beat; the input remainder is discarded after release per REQ-015.
REQ-027 Reset release SHALL take effect on the first tx_clk edge after deassertion.

Verification
REQ-028 SHALL cover: SETTLE_CYCLES=16, stat_rx_aligned high, no traffic -> tx_active rises exactly 4+16 (+1 register) cycles after the rising edge; measure and pin the exact count.
REQ-029 SHALL cover: aligned high, a 4-beat input packet already mid-stream at settle completion -> remaining beats discarded, dropped_packets=1, the next packet is forwarded intact.
REQ-030 SHALL cover: in UP, alignment dropped after beat 2 of a 6-beat packet -> one abort beat (tkeep=all ones, tlast=1, tuser=1), aborted_packets=1, beats 3-6 discarded, dropped_packets=1.
REQ-031 SHALL cover: alignment dropped between packets -> direct UP to DOWN, no abort beat, counters unchanged.
REQ-032 SHALL cover: ABORT with tx_out_tready held low 10 cycles -> abort beat stable for all 10 cycles, exactly one transfer.
REQ-033 SHALL cover: sys_reset_in pulsed in UP mid-packet -> outputs at reset values immediately, no abort beat, counters 0.
